// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, fetch FSM states and the PC increment shared by the pipeline.
package cpu_pkg;
    localparam int INST_W = 32;
    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;
    typedef enum logic [1:0] {F_REQ, F_HOLD, F_SQUASH} fetch_state_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry instruction/PC buffer with load, clear and valid.
module fetch_hold_buf
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] d_inst,
    input  logic [ADDR_W-1:0] d_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= d_inst;
            pc    <= d_pc;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch and IF/ID register with stall, redirect and squash.
// Optional FETCH_PERF_EN adds a saturating fetch_wait_cycles counter output.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall_id,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
`ifdef FETCH_PERF_EN
    output logic [31:0]       fetch_wait_cycles,
`endif
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc
);
    fetch_state_t      state;
    logic [ADDR_W-1:0] pc, tgt;
    logic              hb_valid, hb_load, hb_clear;
    logic [INST_W-1:0] hb_inst;
    logic [ADDR_W-1:0] hb_pc;
    logic              ack, accept;
    logic [ADDR_W-1:0] rtgt;

    assign imem_req  = state != F_HOLD;
    assign imem_addr = pc;
    assign ack       = imem_req && imem_ack;
    assign accept    = !stall_id || !id_valid;
    assign rtgt      = {redirect_target[ADDR_W-1:2], 2'b00};
    assign hb_load   = !redirect_valid && state == F_REQ && ack && !accept;
    assign hb_clear  = redirect_valid || (state == F_HOLD && !stall_id);

    fetch_hold_buf u_hold (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (hb_load),
        .clear  (hb_clear),
        .d_inst (imem_rdata),
        .d_pc   (pc),
        .valid  (hb_valid),
        .inst   (hb_inst),
        .pc     (hb_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= F_REQ;
            pc       <= RESET_PC;
            tgt      <= '0;
            id_valid <= 1'b0;
            id_inst  <= '0;
            id_pc    <= '0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
            id_inst  <= '0;
            // an unacked request must finish at its current address before the PC moves
            if (state != F_HOLD && !ack) begin
                tgt   <= rtgt;
                state <= F_SQUASH;
            end else begin
                pc    <= rtgt;
                state <= F_REQ;
            end
        end else begin
            case (state)
                F_REQ: begin
                    if (ack) begin
                        pc <= pc + PC_STEP;
                        if (accept) begin
                            id_valid <= 1'b1;
                            id_inst  <= imem_rdata;
                            id_pc    <= pc;
                        end else begin
                            state <= F_HOLD;
                        end
                    end else if (accept) begin
                        id_valid <= 1'b0;
                    end
                end
                F_HOLD: begin
                    if (!stall_id) begin
                        id_valid <= hb_valid;
                        id_inst  <= hb_inst;
                        id_pc    <= hb_pc;
                        state    <= F_REQ;
                    end
                end
                default: begin
                    if (accept) id_valid <= 1'b0;
                    if (ack) begin
                        pc    <= tgt;
                        state <= F_REQ;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fetch_wait_cycles <= '0;
        else if (imem_req && !imem_ack && fetch_wait_cycles != 32'hFFFF_FFFF)
            fetch_wait_cycles <= fetch_wait_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of streaming, stall, redirect, wrap and async reset.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [INST_W-1:0] imem_rdata;
    logic              stall_id = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_target = '0;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]       wait_cycles;
`endif
    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // memory returns a word derived from its address
    function automatic logic [INST_W-1:0] mem(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ 32'hCAFE_0000;
    endfunction
    assign imem_rdata = mem(imem_addr);

    fetch_stage #(.RESET_PC(64'h100)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
`ifdef FETCH_PERF_EN
        .fetch_wait_cycles(wait_cycles),
`endif
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_inst", 64'(id_inst), 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);
        chk("rst_addr", imem_addr, 64'h100);
        #9 reset_n = 1'b1;
        imem_ack = 1'b1;
        chk("req_after_rst", 64'(imem_req), 64'd1);
        step();
        chk("s0_id_pc", id_pc, 64'h100);
        chk("s0_id_valid", 64'(id_valid), 64'd1);
        chk("s0_id_inst", 64'(id_inst), 64'(mem(64'h100)));
        chk("s0_addr", imem_addr, 64'h104);
        stall_id = 1'b1;
        step();
        chk("st1_req", 64'(imem_req), 64'd0);
        chk("st1_id_pc", id_pc, 64'h100);
        chk("st1_addr", imem_addr, 64'h108);
        step();
        chk("st2_id_pc", id_pc, 64'h100);
        chk("st2_req", 64'(imem_req), 64'd0);
        step();
        chk("st3_id_pc", id_pc, 64'h100);
        stall_id = 1'b0;
        step();
        chk("rel_id_pc", id_pc, 64'h104);
        chk("rel_id_inst", 64'(id_inst), 64'(mem(64'h104)));
        chk("rel_req", 64'(imem_req), 64'd1);
        chk("rel_addr", imem_addr, 64'h108);
        step();
        chk("s2_id_pc", id_pc, 64'h108);
        chk("s2_addr", imem_addr, 64'h10C);
        imem_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 64'h200;
        step();
        redirect_valid = 1'b0;
        chk("sq_id_valid", 64'(id_valid), 64'd0);
        chk("sq_id_inst", 64'(id_inst), 64'd0);
        chk("sq_addr", imem_addr, 64'h10C);
        chk("sq_req", 64'(imem_req), 64'd1);
        step();
        chk("sq_wait_addr", imem_addr, 64'h10C);
        imem_ack = 1'b1;
        step();
        chk("sq_done_addr", imem_addr, 64'h200);
        chk("sq_done_valid", 64'(id_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_target = 64'h1FE;
        step();
        redirect_valid = 1'b0;
        chk("col_addr", imem_addr, 64'h1FC);
        chk("col_id_valid", 64'(id_valid), 64'd0);
        chk("col_id_inst", 64'(id_inst), 64'd0);
        step();
        chk("col_next_id_pc", id_pc, 64'h1FC);
        chk("col_next_inst", 64'(id_inst), 64'(mem(64'h1FC)));
        chk("col_next_addr", imem_addr, 64'h200);
        redirect_valid = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_next", imem_addr, 64'h0);
        imem_ack = 1'b0;
        step();
        chk("bubble_valid", 64'(id_valid), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_id_pc", id_pc, 64'd0);
        chk("arst_id_valid", 64'(id_valid), 64'd0);
        chk("arst_addr", imem_addr, 64'h100);
        chk("arst_req", 64'(imem_req), 64'd1);
        #3 reset_n = 1'b1;
        imem_ack = 1'b1;
        step();
        chk("restart_id_pc", id_pc, 64'h100);
        chk("restart_addr", imem_addr, 64'h104);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
